// File: rtl/axi_pkg.sv
// Shared definitions for the AXI-Stream helper blocks: streamer FSM
// encoding and the default output-buffer depth.
package axi_pkg;

    localparam int FIFO_DEPTH_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } stream_state_e;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry first-word-fall-through buffer; the head entry is a register
// that drives o_data directly, so the output never glitches.
module stream_fifo2 #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [1:0]   r_count;
    logic         w_pop;
    logic         w_push;

    // A push into a full buffer is only legal when the head leaves this cycle.
    always_comb begin
        w_pop  = i_pop && (r_count != 2'd0);
        w_push = i_push && ((r_count != 2'd2) || w_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= i_data;
                    else                 r_tail <= i_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_data  = r_head;
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/bram_rd_streamer.sv
// Reads a contiguous (wrapping) BRAM region and emits it as an AXI4-Stream
// byte stream, with credit-based read issue into a 2-entry output buffer.
module bram_rd_streamer
    import axi_pkg::*;
#(
    parameter int ADDR_BW    = 8,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [ADDR_BW-1:0] i_base_addr,
    input  logic [ADDR_BW:0]   i_len,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_r_en,
    output logic [ADDR_BW-1:0] o_r_addr,
    input  logic [7:0]         i_r_data,
    output logic               o_tvalid,
    output logic [7:0]         o_tdata,
    output logic               o_tlast,
    input  logic               i_tready,
    output stream_state_e      o_state
);

    localparam logic [ADDR_BW:0]   LEN_ONE  = (ADDR_BW + 1)'(1);
    localparam logic [ADDR_BW-1:0] ADDR_ONE = ADDR_BW'(1);

    stream_state_e      r_state;
    stream_state_e      w_next_state;
    logic               r_armed;
    logic [ADDR_BW-1:0] r_addr;
    logic [ADDR_BW:0]   r_rd_left;
    logic               r_inflight;
    logic               r_inflight_last;

    logic               w_pop;
    logic               w_rd_issue;
    logic               w_rd_last;
    logic [2:0]         w_occ;
    logic [2:0]         w_credit;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [8:0]         w_fifo_dout;

    // Read data returns one cycle after issue, so at most one read is in
    // flight; a new read is allowed only if it is guaranteed a buffer slot.
    always_comb begin
        w_pop      = !w_fifo_empty && i_tready;
        w_occ      = w_fifo_full ? 3'd2 : (w_fifo_empty ? 3'd0 : 3'd1);
        w_credit   = w_occ + {2'b00, r_inflight} - {2'b00, w_pop};
        // r_armed holds off the first RUN cycle so the first read follows
        // acceptance by two edges and the first beat by three.
        w_rd_issue = (r_state == ST_RUN) && r_armed && (r_rd_left != '0)
                     && (w_credit < 3'(FIFO_DEPTH));
        w_rd_last  = w_rd_issue && (r_rd_left == LEN_ONE);
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_next_state = (i_len == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (w_rd_last) w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_pop && w_fifo_dout[8]) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_armed         <= 1'b0;
            r_addr          <= '0;
            r_rd_left       <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_armed         <= (r_state == ST_RUN);
            r_inflight      <= w_rd_issue;
            r_inflight_last <= w_rd_last;
            if ((r_state == ST_IDLE) && i_start) begin
                r_addr    <= i_base_addr;
                r_rd_left <= i_len;
            end else if (w_rd_issue) begin
                r_addr    <= r_addr + ADDR_ONE;
                r_rd_left <= r_rd_left - LEN_ONE;
            end
        end
    end

    stream_fifo2 #(
        .W (9)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_data  ({r_inflight_last, i_r_data}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign o_busy   = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign o_done   = (r_state == ST_DONE);
    assign o_r_en   = w_rd_issue;
    assign o_r_addr = r_addr;
    assign o_tvalid = !w_fifo_empty;
    assign o_tdata  = w_fifo_dout[7:0];
    assign o_tlast  = !w_fifo_empty && w_fifo_dout[8];
    assign o_state  = r_state;

endmodule
